// File: rtl/qpu_dtcm_icb_arbt.sv
// Two-master ICB arbiter sharing the DTCM port between the LSU (m0) and the result writer (m1).
// One outstanding transaction, round-robin grant, grant locked while a command is stalled.
module qpu_dtcm_icb_arbt #(
   parameter int unsigned AW = 16,
   parameter int unsigned DW = 32,
   parameter int unsigned MW = 4
) (
   input  logic          clk,
   input  logic          rst_n,

   input  logic          m0_icb_cmd_valid,
   output logic          m0_icb_cmd_ready,
   input  logic [AW-1:0] m0_icb_cmd_addr,
   input  logic          m0_icb_cmd_read,
   input  logic [DW-1:0] m0_icb_cmd_wdata,
   input  logic [MW-1:0] m0_icb_cmd_wmask,
   output logic          m0_icb_rsp_valid,
   input  logic          m0_icb_rsp_ready,
   output logic [DW-1:0] m0_icb_rsp_rdata,

   input  logic          m1_icb_cmd_valid,
   output logic          m1_icb_cmd_ready,
   input  logic [AW-1:0] m1_icb_cmd_addr,
   input  logic          m1_icb_cmd_read,
   input  logic [DW-1:0] m1_icb_cmd_wdata,
   input  logic [MW-1:0] m1_icb_cmd_wmask,
   output logic          m1_icb_rsp_valid,
   input  logic          m1_icb_rsp_ready,
   output logic [DW-1:0] m1_icb_rsp_rdata,

   output logic          o_icb_cmd_valid,
   input  logic          o_icb_cmd_ready,
   output logic [AW-1:0] o_icb_cmd_addr,
   output logic          o_icb_cmd_read,
   output logic [DW-1:0] o_icb_cmd_wdata,
   output logic [MW-1:0] o_icb_cmd_wmask,
   input  logic          o_icb_rsp_valid,
   output logic          o_icb_rsp_ready,
   input  logic [DW-1:0] o_icb_rsp_rdata,

   output logic          arbt_active
);

   typedef enum logic {IDLE = 1'b0, WAIT_RSP = 1'b1} state_t;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic          read;
      logic [DW-1:0] wdata;
      logic [MW-1:0] wmask;
   } icb_cmd_t;

   state_t   state;
   logic     owner;
   logic     last_grant;
   logic     lock;
   logic     lock_id;

   logic     sel;
   logic     any_valid;
   logic     cmd_hs;
   logic     rsp_hs;
   icb_cmd_t m0_cmd;
   icb_cmd_t m1_cmd;
   icb_cmd_t mux_cmd;

   assign any_valid = m0_icb_cmd_valid | m1_icb_cmd_valid;

   // Locked grant wins; a lone requester wins; a tie goes to the master not granted last.
   always_comb begin
      sel = ~last_grant;
      if (lock) begin
         sel = lock_id;
      end else if (m0_icb_cmd_valid ^ m1_icb_cmd_valid) begin
         sel = m1_icb_cmd_valid;
      end
   end

   always_comb begin
      m0_cmd = '{addr: m0_icb_cmd_addr, read: m0_icb_cmd_read,
                 wdata: m0_icb_cmd_wdata, wmask: m0_icb_cmd_wmask};
      m1_cmd = '{addr: m1_icb_cmd_addr, read: m1_icb_cmd_read,
                 wdata: m1_icb_cmd_wdata, wmask: m1_icb_cmd_wmask};
      mux_cmd = sel ? m1_cmd : m0_cmd;
   end

   assign o_icb_cmd_addr   = mux_cmd.addr;
   assign o_icb_cmd_read   = mux_cmd.read;
   assign o_icb_cmd_wdata  = mux_cmd.wdata;
   assign o_icb_cmd_wmask  = mux_cmd.wmask;

   assign m0_icb_rsp_rdata = o_icb_rsp_rdata;
   assign m1_icb_rsp_rdata = o_icb_rsp_rdata;

   assign cmd_hs      = (state == IDLE) & any_valid & o_icb_cmd_ready;
   assign rsp_hs      = (state == WAIT_RSP) & o_icb_rsp_valid & o_icb_rsp_ready;
   assign arbt_active = any_valid | (state == WAIT_RSP);

   // Handshake routing; a response arriving in IDLE is drained and routed nowhere.
   always_comb begin
      o_icb_cmd_valid  = 1'b0;
      m0_icb_cmd_ready = 1'b0;
      m1_icb_cmd_ready = 1'b0;
      m0_icb_rsp_valid = 1'b0;
      m1_icb_rsp_valid = 1'b0;
      o_icb_rsp_ready  = 1'b0;
      if (state == IDLE) begin
         o_icb_cmd_valid  = any_valid;
         m0_icb_cmd_ready = any_valid & ~sel & o_icb_cmd_ready;
         m1_icb_cmd_ready = any_valid &  sel & o_icb_cmd_ready;
         o_icb_rsp_ready  = o_icb_rsp_valid;
      end else begin
         m0_icb_rsp_valid = o_icb_rsp_valid & ~owner;
         m1_icb_rsp_valid = o_icb_rsp_valid &  owner;
         o_icb_rsp_ready  = owner ? m1_icb_rsp_ready : m0_icb_rsp_ready;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         lock       <= 1'b0;
         lock_id    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_hs) begin
                  owner      <= sel;
                  last_grant <= sel;
                  lock       <= 1'b0;
                  state      <= WAIT_RSP;
               end else if (any_valid) begin
                  lock       <= 1'b1;
                  lock_id    <= sel;
               end
            end
            WAIT_RSP: begin
               if (rsp_hs) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_qpu_dtcm_icb_arbt.sv
// Self-checking bench for qpu_dtcm_icb_arbt: scenario tasks plus a command/response scoreboard.
module tb_qpu_dtcm_icb_arbt;

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 32;
   localparam int unsigned MW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          m0_icb_cmd_valid, m0_icb_cmd_ready, m0_icb_cmd_read;
   logic [AW-1:0] m0_icb_cmd_addr;
   logic [DW-1:0] m0_icb_cmd_wdata, m0_icb_rsp_rdata;
   logic [MW-1:0] m0_icb_cmd_wmask;
   logic          m0_icb_rsp_valid, m0_icb_rsp_ready;
   logic          m1_icb_cmd_valid, m1_icb_cmd_ready, m1_icb_cmd_read;
   logic [AW-1:0] m1_icb_cmd_addr;
   logic [DW-1:0] m1_icb_cmd_wdata, m1_icb_rsp_rdata;
   logic [MW-1:0] m1_icb_cmd_wmask;
   logic          m1_icb_rsp_valid, m1_icb_rsp_ready;
   logic          o_icb_cmd_valid, o_icb_cmd_ready, o_icb_cmd_read;
   logic [AW-1:0] o_icb_cmd_addr;
   logic [DW-1:0] o_icb_cmd_wdata, o_icb_rsp_rdata;
   logic [MW-1:0] o_icb_cmd_wmask;
   logic          o_icb_rsp_valid, o_icb_rsp_ready;
   logic          arbt_active;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic          owner;
      logic [DW-1:0] wdata;
   } exp_t;
   exp_t exp_q[$];

   qpu_dtcm_icb_arbt #(.AW(AW), .DW(DW), .MW(MW)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_icb_cmd_valid(m0_icb_cmd_valid), .m0_icb_cmd_ready(m0_icb_cmd_ready),
      .m0_icb_cmd_addr(m0_icb_cmd_addr), .m0_icb_cmd_read(m0_icb_cmd_read),
      .m0_icb_cmd_wdata(m0_icb_cmd_wdata), .m0_icb_cmd_wmask(m0_icb_cmd_wmask),
      .m0_icb_rsp_valid(m0_icb_rsp_valid), .m0_icb_rsp_ready(m0_icb_rsp_ready),
      .m0_icb_rsp_rdata(m0_icb_rsp_rdata),
      .m1_icb_cmd_valid(m1_icb_cmd_valid), .m1_icb_cmd_ready(m1_icb_cmd_ready),
      .m1_icb_cmd_addr(m1_icb_cmd_addr), .m1_icb_cmd_read(m1_icb_cmd_read),
      .m1_icb_cmd_wdata(m1_icb_cmd_wdata), .m1_icb_cmd_wmask(m1_icb_cmd_wmask),
      .m1_icb_rsp_valid(m1_icb_rsp_valid), .m1_icb_rsp_ready(m1_icb_rsp_ready),
      .m1_icb_rsp_rdata(m1_icb_rsp_rdata),
      .o_icb_cmd_valid(o_icb_cmd_valid), .o_icb_cmd_ready(o_icb_cmd_ready),
      .o_icb_cmd_addr(o_icb_cmd_addr), .o_icb_cmd_read(o_icb_cmd_read),
      .o_icb_cmd_wdata(o_icb_cmd_wdata), .o_icb_cmd_wmask(o_icb_cmd_wmask),
      .o_icb_rsp_valid(o_icb_rsp_valid), .o_icb_rsp_ready(o_icb_rsp_ready),
      .o_icb_rsp_rdata(o_icb_rsp_rdata),
      .arbt_active(arbt_active)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Advance to just after the next rising edge; inputs change and outputs are sampled there.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      m0_icb_cmd_valid = 1'b0; m0_icb_cmd_addr = '0; m0_icb_cmd_read = 1'b0;
      m0_icb_cmd_wdata = '0;   m0_icb_cmd_wmask = '1; m0_icb_rsp_ready = 1'b1;
      m1_icb_cmd_valid = 1'b0; m1_icb_cmd_addr = '0; m1_icb_cmd_read = 1'b0;
      m1_icb_cmd_wdata = '0;   m1_icb_cmd_wmask = '1; m1_icb_rsp_ready = 1'b1;
      o_icb_cmd_ready  = 1'b1; o_icb_rsp_valid = 1'b0; o_icb_rsp_rdata = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++;
      if ({o_icb_cmd_valid, m0_icb_cmd_ready, m1_icb_cmd_ready, m0_icb_rsp_valid,
           m1_icb_rsp_valid, o_icb_rsp_ready, arbt_active} !== 7'b0) begin
         failures++;
         $display("FAIL reset_outputs: got %b required 0000000",
                  {o_icb_cmd_valid, m0_icb_cmd_ready, m1_icb_cmd_ready, m0_icb_rsp_valid,
                   m1_icb_rsp_valid, o_icb_rsp_ready, arbt_active});
      end
   endtask

   task automatic test_single_read();
      do_reset();
      m0_icb_cmd_valid = 1'b1; m0_icb_cmd_read = 1'b1; m0_icb_cmd_addr = 16'h0010;
      #1;
      checks++;
      if ({o_icb_cmd_valid, m0_icb_cmd_ready, m1_icb_cmd_ready, o_icb_cmd_read} !== 4'b1101
          || o_icb_cmd_addr !== 16'h0010) begin
         failures++;
         $display("FAIL single_cmd: v/r0/r1/rd=%b addr=%h required 1101 addr=0010",
                  {o_icb_cmd_valid, m0_icb_cmd_ready, m1_icb_cmd_ready, o_icb_cmd_read},
                  o_icb_cmd_addr);
      end
      next_cycle();
      m0_icb_cmd_valid = 1'b0;
      o_icb_rsp_valid = 1'b1; o_icb_rsp_rdata = 32'hDEADBEEF;
      #1;
      checks++;
      if ({m0_icb_rsp_valid, m1_icb_rsp_valid, o_icb_rsp_ready} !== 3'b101
          || m0_icb_rsp_rdata !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL single_rsp: rv0/rv1/ordy=%b rdata=%h required 101 rdata=deadbeef",
                  {m0_icb_rsp_valid, m1_icb_rsp_valid, o_icb_rsp_ready}, m0_icb_rsp_rdata);
      end
      next_cycle();
      o_icb_rsp_valid = 1'b0;
      #1;
      checks++;
      if (arbt_active !== 1'b0) begin
         failures++;
         $display("FAIL single_idle: arbt_active=%b required 0", arbt_active);
      end
   endtask

   // Both masters stream writes; the scoreboard holds the required DTCM order and owners.
   task automatic test_contention();
      int   i0 = 0;
      int   i1 = 0;
      int   done = 0;
      logic pend = 1'b0;
      logic pend_owner = 1'b0;
      exp_t e;
      do_reset();
      exp_q.delete();
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back('{owner: 1'b0, wdata: 32'(32'hA0 + k)});
         exp_q.push_back('{owner: 1'b1, wdata: 32'(32'hB0 + k)});
      end
      for (int c = 0; c < 60 && done < 8; c++) begin
         m0_icb_cmd_valid = (i0 < 4); m0_icb_cmd_wdata = 32'(32'hA0 + i0);
         m0_icb_cmd_addr  = 16'(16'h0100 + 4 * i0);
         m1_icb_cmd_valid = (i1 < 4); m1_icb_cmd_wdata = 32'(32'hB0 + i1);
         m1_icb_cmd_addr  = 16'(16'h0200 + 4 * i1);
         o_icb_rsp_valid  = pend;     o_icb_rsp_rdata = 32'(32'h5000 + c);
         #1;
         if (pend) begin
            checks++;
            if ({m0_icb_rsp_valid, m1_icb_rsp_valid} !== (pend_owner ? 2'b01 : 2'b10)
                || m0_icb_rsp_rdata !== o_icb_rsp_rdata || m1_icb_rsp_rdata !== o_icb_rsp_rdata) begin
               failures++;
               $display("FAIL contention_rsp: rv0/rv1=%b required owner %0d",
                        {m0_icb_rsp_valid, m1_icb_rsp_valid}, pend_owner);
            end
            pend = 1'b0;
            done++;
         end else if (o_icb_cmd_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL contention_extra: unexpected command wdata=%h", o_icb_cmd_wdata);
            end else begin
               e = exp_q.pop_front();
               if (o_icb_cmd_wdata !== e.wdata
                   || {m0_icb_cmd_ready, m1_icb_cmd_ready} !== (e.owner ? 2'b01 : 2'b10)) begin
                  failures++;
                  $display("FAIL contention_order: wdata=%h r0/r1=%b required wdata=%h owner %0d",
                           o_icb_cmd_wdata, {m0_icb_cmd_ready, m1_icb_cmd_ready}, e.wdata, e.owner);
               end
               pend = 1'b1;
               pend_owner = e.owner;
            end
            if (m0_icb_cmd_ready) i0++;
            if (m1_icb_cmd_ready) i1++;
         end
         next_cycle();
      end
      checks++;
      if (done != 8 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL contention_timeout: responses=%0d pending=%0d required 8/0", done, exp_q.size());
      end
      idle_inputs();
   endtask

   task automatic test_lock();
      do_reset();
      o_icb_cmd_ready = 1'b0;
      m1_icb_cmd_valid = 1'b1; m1_icb_cmd_addr = 16'h0200;
      for (int c = 0; c < 3; c++) begin
         if (c == 1) begin
            m0_icb_cmd_valid = 1'b1; m0_icb_cmd_addr = 16'h0100;
         end
         #1;
         checks++;
         if (o_icb_cmd_addr !== 16'h0200 || o_icb_cmd_valid !== 1'b1
             || {m0_icb_cmd_ready, m1_icb_cmd_ready} !== 2'b00) begin
            failures++;
            $display("FAIL lock_stall%0d: addr=%h v=%b r0/r1=%b required addr=0200 v=1 r=00",
                     c, o_icb_cmd_addr, o_icb_cmd_valid, {m0_icb_cmd_ready, m1_icb_cmd_ready});
         end
         next_cycle();
      end
      o_icb_cmd_ready = 1'b1;
      #1;
      checks++;
      if ({m0_icb_cmd_ready, m1_icb_cmd_ready} !== 2'b01 || o_icb_cmd_addr !== 16'h0200) begin
         failures++;
         $display("FAIL lock_grant_m1: r0/r1=%b addr=%h required 01 addr=0200",
                  {m0_icb_cmd_ready, m1_icb_cmd_ready}, o_icb_cmd_addr);
      end
      next_cycle();
      m1_icb_cmd_valid = 1'b0;
      o_icb_rsp_valid = 1'b1;
      #1;
      checks++;
      if ({m0_icb_rsp_valid, m1_icb_rsp_valid} !== 2'b01) begin
         failures++;
         $display("FAIL lock_rsp_m1: rv0/rv1=%b required 01", {m0_icb_rsp_valid, m1_icb_rsp_valid});
      end
      next_cycle();
      o_icb_rsp_valid = 1'b0;
      #1;
      checks++;
      if ({m0_icb_cmd_ready, m1_icb_cmd_ready} !== 2'b10 || o_icb_cmd_addr !== 16'h0100) begin
         failures++;
         $display("FAIL lock_grant_m0: r0/r1=%b addr=%h required 10 addr=0100",
                  {m0_icb_cmd_ready, m1_icb_cmd_ready}, o_icb_cmd_addr);
      end
      next_cycle();
      m0_icb_cmd_valid = 1'b0;
      o_icb_rsp_valid = 1'b1;
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_backpressure();
      do_reset();
      m0_icb_cmd_valid = 1'b1; m0_icb_cmd_read = 1'b1; m0_icb_cmd_addr = 16'h0030;
      m1_icb_cmd_valid = 1'b1; m1_icb_cmd_addr = 16'h0040;
      #1;
      checks++;
      if ({m0_icb_cmd_ready, m1_icb_cmd_ready} !== 2'b10) begin
         failures++;
         $display("FAIL bp_first_grant: r0/r1=%b required 10", {m0_icb_cmd_ready, m1_icb_cmd_ready});
      end
      next_cycle();
      m0_icb_cmd_valid = 1'b0; m0_icb_rsp_ready = 1'b0;
      o_icb_rsp_valid = 1'b1; o_icb_rsp_rdata = 32'h0000C0DE;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++;
         if ({m1_icb_cmd_ready, o_icb_cmd_valid, o_icb_rsp_ready, m0_icb_rsp_valid, arbt_active} !== 5'b00011) begin
            failures++;
            $display("FAIL bp_hold%0d: r1/ov/ordy/rv0/act=%b required 00011", c,
                     {m1_icb_cmd_ready, o_icb_cmd_valid, o_icb_rsp_ready, m0_icb_rsp_valid, arbt_active});
         end
         next_cycle();
      end
      m0_icb_rsp_ready = 1'b1;
      #1;
      checks++;
      if ({o_icb_rsp_ready, m1_icb_cmd_ready} !== 2'b10) begin
         failures++;
         $display("FAIL bp_release: ordy/r1=%b required 10", {o_icb_rsp_ready, m1_icb_cmd_ready});
      end
      next_cycle();
      o_icb_rsp_valid = 1'b0;
      #1;
      checks++;
      if (m1_icb_cmd_ready !== 1'b1 || o_icb_cmd_addr !== 16'h0040) begin
         failures++;
         $display("FAIL bp_m1_next: r1=%b addr=%h required 1 addr=0040", m1_icb_cmd_ready, o_icb_cmd_addr);
      end
      next_cycle();
      m1_icb_cmd_valid = 1'b0;
      o_icb_rsp_valid = 1'b1;
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      do_reset();
      m1_icb_cmd_valid = 1'b1; m1_icb_cmd_addr = 16'h0080;
      next_cycle();
      m1_icb_cmd_valid = 1'b0;
      o_icb_rsp_valid = 1'b1;
      #1;
      checks++;
      if (m1_icb_rsp_valid !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_pre: m1_rsp_valid=%b required 1", m1_icb_rsp_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({m1_icb_rsp_valid, arbt_active} !== 2'b00) begin
         failures++;
         $display("FAIL rstmid_async: rv1/act=%b required 00", {m1_icb_rsp_valid, arbt_active});
      end
      o_icb_rsp_valid = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
      m0_icb_cmd_valid = 1'b1; m1_icb_cmd_valid = 1'b1;
      #1;
      checks++;
      if ({m0_icb_cmd_ready, m1_icb_cmd_ready} !== 2'b10) begin
         failures++;
         $display("FAIL rstmid_tie: r0/r1=%b required 10", {m0_icb_cmd_ready, m1_icb_cmd_ready});
      end
      idle_inputs();
   endtask

   task automatic test_stray_rsp();
      do_reset();
      o_icb_rsp_valid = 1'b1; o_icb_rsp_rdata = 32'h12345678;
      #1;
      checks++;
      if ({o_icb_rsp_ready, m0_icb_rsp_valid, m1_icb_rsp_valid, arbt_active} !== 4'b1000) begin
         failures++;
         $display("FAIL stray_drain: ordy/rv0/rv1/act=%b required 1000",
                  {o_icb_rsp_ready, m0_icb_rsp_valid, m1_icb_rsp_valid, arbt_active});
      end
      next_cycle();
      o_icb_rsp_valid = 1'b0;
      m1_icb_cmd_valid = 1'b1;
      #1;
      checks++;
      if ({o_icb_cmd_valid, m1_icb_cmd_ready} !== 2'b11) begin
         failures++;
         $display("FAIL stray_still_idle: ov/r1=%b required 11", {o_icb_cmd_valid, m1_icb_cmd_ready});
      end
      idle_inputs();
   endtask

   initial begin
      rst_n = 1'b1;
      idle_inputs();
      test_reset();
      test_single_read();
      test_contention();
      test_lock();
      test_backpressure();
      test_reset_mid();
      test_stray_rsp();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/qpu_dtcm_icb_arbt.md
# qpu_dtcm_icb_arbt

Two-master ICB arbiter in front of the DTCM SRAM controller. It shares the single DTCM ICB port between the LSU (master 0) and the measurement-result writer (master 1). The writer streams qubit readout results into DTCM. The arbiter allows one outstanding transaction, grants round-robin with a lock while a command is stalled, and returns each response to the master that issued the command. It sits between the LSU/result writer and the DTCM controller's LSU-side ICB port.

## Interface
- AW, 16, ICB byte-address width (matches DTCM address width)
- DW, 32, data width
- MW, 4, write-mask width (DW/8)

Ports:
- clk  in  1  single clock; all state in this domain
- rst_n  in  1  reset; asynchronous, active-low
- m0_icb_cmd_valid / m1_icb_cmd_valid  in  1  command request
- m0_icb_cmd_ready / m1_icb_cmd_ready  out  1  command accepted
- m0_icb_cmd_addr / m1_icb_cmd_addr  in  AW  byte address
- m0_icb_cmd_read / m1_icb_cmd_read  in  1  1=read, 0=write
- m0_icb_cmd_wdata / m1_icb_cmd_wdata  in  DW  write data
- m0_icb_cmd_wmask / m1_icb_cmd_wmask  in  MW  byte write mask
- m0_icb_rsp_valid / m1_icb_rsp_valid  out  1  response valid
- m0_icb_rsp_ready / m1_icb_rsp_ready  in  1  response accepted
- m0_icb_rsp_rdata / m1_icb_rsp_rdata  out  DW  read data (copy of o_icb_rsp_rdata to both)
- o_icb_cmd_valid  out  1  command to DTCM controller
- o_icb_cmd_ready  in  1
- o_icb_cmd_addr / o_icb_cmd_read / o_icb_cmd_wdata / o_icb_cmd_wmask  out  AW/1/DW/MW  muxed command fields
- o_icb_rsp_valid  in  1
- o_icb_rsp_ready  out  1
- o_icb_rsp_rdata  in  DW
- arbt_active  out  1  any cmd valid, or a transaction is outstanding (feeds DTCM clock-gating enable)

## Operation
- State machine: IDLE (no outstanding) and WAIT_RSP (one outstanding; `owner` register holds its master index).
- IDLE:
  - o_icb_cmd_valid = m0_valid | m1_valid.
  - Selection `sel`:
    - If `lock` is set, `sel` = `lock_id`.
    - Otherwise, if only one master is valid, that master.
    - Otherwise (both valid), the master that is not `last_grant`.
  - Command fields are muxed from `sel`.
  - m[sel]_icb_cmd_ready = o_icb_cmd_ready. The non-selected master's ready is 0.
- Lock: in IDLE, if o_icb_cmd_valid=1 and o_icb_cmd_ready=0, set lock=1 and lock_id=sel on the next edge. This prevents the grant from switching under a stalled command. Lock clears on the command handshake.
- Command handshake (IDLE, o_icb_cmd_valid & o_icb_cmd_ready):
  - owner <= sel
  - last_grant <= sel
  - lock <= 0
  - state <= WAIT_RSP
- WAIT_RSP:
  - o_icb_cmd_valid=0; both m*_icb_cmd_ready=0.
  - m[owner]_icb_rsp_valid = o_icb_rsp_valid; the other master's rsp_valid is 0.
  - o_icb_rsp_ready = m[owner]_icb_rsp_ready.
  - On the response handshake, state <= IDLE.
- o_icb_rsp_valid in IDLE is a protocol error. The arbiter routes it nowhere, holds o_icb_rsp_ready=1 to drain it, and stays in IDLE.
- A master that drops cmd_valid while locked without a handshake violates ICB. Behaviour is undefined; it is not required to be handled.
- arbt_active = m0_icb_cmd_valid | m1_icb_cmd_valid | (state==WAIT_RSP).

## Timing
- Reset values: state=IDLE, owner=0, last_grant=1 (master 0 wins the first tie), lock=0, lock_id=0.
- All outputs are combinational from state and inputs. With all input valids low after reset, every valid/ready output is 0 and arbt_active=0.
- Arbitration adds zero cycles: a master's command reaches o_icb_* in the same cycle it is asserted.
- Earliest response is the cycle after the command handshake (DTCM read latency 1). The response passes through combinationally.
- Throughput: at most one command per two cycles. The next command handshake is possible in the cycle after the response handshake.
- Simultaneous requests: grants alternate strictly (0,1,0,1...) while both stay valid. A single requester is granted back-to-back regardless of last_grant.
- Response back-pressure: WAIT_RSP persists while m[owner]_icb_rsp_ready=0. The other master stays blocked for that time.
- Asynchronous reset mid-transaction clears state and owner immediately. The outstanding response is dropped; the DTCM controller shares rst_n, so it is flushed as well.

## Test plan
- Single LSU read:
  - Stimulus: m0 read addr 0x0010, ready=1; DTCM returns 0xDEADBEEF.
  - Required: m0 cmd handshake in cycle 0; m0_rsp_valid=1 with rdata 0xDEADBEEF in cycle 1; m1_rsp_valid stays 0.
- Contention:
  - Stimulus: m0 and m1 hold valid continuously, each issuing 4 writes (m0 wdata 0xA0..A3, m1 wdata 0xB0..B3).
  - Required: DTCM sees order A0,B0,A1,B1,A2,B2,A3,B3; each response is routed to its issuer.
- Lock:
  - Stimulus: o_icb_cmd_ready=0 for 3 cycles with m1 valid alone; m0 raises valid in cycle 1.
  - Required: o_icb_cmd_addr stays m1's for all stall cycles; m1 is granted first, then m0.
- Response back-pressure:
  - Stimulus: m0 read with m0_rsp_ready=0 for 5 cycles; m1 valid throughout.
  - Required: m1_cmd_ready=0 for all 5 cycles; m1 is granted the cycle after m0's response handshake.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 while in WAIT_RSP for owner=1.
  - Required: immediately m1_rsp_valid=0 and arbt_active=0 (inputs idle); after release, a tie is granted to m0.
- Stray response:
  - Stimulus: o_icb_rsp_valid=1 in IDLE.
  - Required: o_icb_rsp_ready=1, both m*_rsp_valid=0, state remains IDLE.
